// File: rtl/fft_twiddle_sequencer.sv
// Purpose: steps through every (stage, butterfly) of an iterative radix-2 DIT FFT and emits W = cos - j*sin.
// Latency: first twiddle valid 1 cycle after start; afterwards one twiddle per accepted transfer.
// Backpressure: out_val/out_rdy handshake; all outputs hold while out_val & !out_rdy.
module fft_twiddle_sequencer #(
  parameter int BIT_WIDTH     = 32,
  parameter int DECIMAL_POINT = 16,
  parameter int SIZE_FFT      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BIT_WIDTH-1:0]          sine_wave_in [0:SIZE_FFT-1],
  input  logic                          start,
  output logic                          busy,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [BIT_WIDTH-1:0]          twiddle_real,
  output logic [BIT_WIDTH-1:0]          twiddle_imag,
  output logic [$clog2(SIZE_FFT)-1:0]   stage,
  output logic [$clog2(SIZE_FFT)-2:0]   bfly_idx,
  output logic                          done
);

  localparam int SW = $clog2(SIZE_FFT);   // stage / table-index width
  localparam int BW = SW - 1;             // butterfly index width

  localparam logic [SW-1:0] STAGE_LAST   = SW'(SW - 1);
  localparam logic [BW-1:0] BFLY_LAST    = BW'(SIZE_FFT / 2 - 1);
  localparam logic [SW-1:0] QUARTER_TURN = SW'(SIZE_FFT / 4);

  // The table must be a full power-of-two period and the format must leave an integer bit.
  if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0 || DECIMAL_POINT >= BIT_WIDTH) begin : g_param_check
    $error("fft_twiddle_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [BW-1:0]         bfly_q, bfly_d;
  logic [BIT_WIDTH-1:0]  tw_re_q, tw_re_d;
  logic [BIT_WIDTH-1:0]  tw_im_q, tw_im_d;

  logic                  load;
  logic [SW-1:0]         nxt_stage;
  logic [BW-1:0]         nxt_bfly;
  logic [SW-1:0]         k_idx;
  logic [SW-1:0]         cos_idx;

  // k = (b mod 2^s) << (log2N-1-s); always below N/2 so it fits the table index width.
  function automatic logic [SW-1:0] twiddle_k(input logic [SW-1:0] s, input logic [BW-1:0] b);
    logic [SW-1:0] mask;
    logic [SW-1:0] j;
    mask = (SW'(1) << s) - SW'(1);
    j    = {1'b0, b} & mask;
    return j << (STAGE_LAST - s);
  endfunction

  // Next-state, next (s,b) and the twiddle that goes with it, loaded on the same edge.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    tw_re_d   = tw_re_q;
    tw_im_d   = tw_im_q;
    load      = 1'b0;
    nxt_stage = '0;
    nxt_bfly  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        // out_val is high for the whole of RUN, so out_rdy alone marks a transfer.
        if (out_rdy) begin
          if (bfly_q == BFLY_LAST) begin
            if (stage_q == STAGE_LAST) begin
              state_d = ST_DONE;
            end else begin
              load      = 1'b1;
              nxt_stage = stage_q + SW'(1);
              nxt_bfly  = '0;
            end
          end else begin
            load      = 1'b1;
            nxt_stage = stage_q;
            nxt_bfly  = bfly_q + BW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    k_idx   = twiddle_k(nxt_stage, nxt_bfly);
    cos_idx = k_idx + QUARTER_TURN;   // wraps modulo N by width

    if (load) begin
      stage_d = nxt_stage;
      bfly_d  = nxt_bfly;
      tw_re_d = sine_wave_in[cos_idx];
      tw_im_d = BIT_WIDTH'(0) - sine_wave_in[k_idx];
    end
  end

  // State and output registers; reset drops everything back to an idle, zeroed port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      tw_re_q <= '0;
      tw_im_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      tw_re_q <= tw_re_d;
      tw_im_q <= tw_im_d;
    end
  end

  // Handshake flags are pure decodes of the state register, so out_rdy never reaches out_val.
  assign busy         = (state_q == ST_RUN);
  assign out_val      = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign twiddle_real = tw_re_q;
  assign twiddle_imag = tw_im_q;
  assign stage        = stage_q;
  assign bfly_idx     = bfly_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer at N=32, Q16.16.
// Table entries are sin(2*pi*i/32)*65536 truncated toward zero, matching the reference vectors.
// Inputs change and outputs are sampled on the falling edge.
module tb_fft_twiddle_sequencer;

  localparam int BIT_WIDTH     = 32;
  localparam int DECIMAL_POINT = 16;
  localparam int SIZE_FFT      = 32;
  localparam int NTX           = 80;

  logic        clk;
  logic        reset;
  logic [31:0] tab [0:SIZE_FFT-1];
  logic        start;
  logic        busy;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] twiddle_real;
  logic [31:0] twiddle_imag;
  logic [4:0]  stage;
  logic [3:0]  bfly_idx;
  logic        done;

  logic [31:0] cap_re [0:NTX-1];
  logic [31:0] cap_im [0:NTX-1];

  int n_chk;
  int n_err;

  fft_twiddle_sequencer #(
    .BIT_WIDTH    (BIT_WIDTH),
    .DECIMAL_POINT(DECIMAL_POINT),
    .SIZE_FFT     (SIZE_FFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sine_wave_in(tab),
    .start       (start),
    .busy        (busy),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .twiddle_real(twiddle_real),
    .twiddle_imag(twiddle_imag),
    .stage       (stage),
    .bfly_idx    (bfly_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%08h) want=%0d (0x%08h)", tag, act, act, exp, exp);
    end
  endtask

  // Expected twiddle for transfer n: s = n/16, b = n%16, k = (b mod 2^s) * N/2^(s+1).
  function automatic int exp_k(input int n);
    int s;
    int b;
    s = n / 16;
    b = n % 16;
    return (b % (1 << s)) * (SIZE_FFT / (1 << (s + 1)));
  endfunction

  function automatic logic [31:0] exp_re(input int n);
    return tab[(exp_k(n) + SIZE_FFT / 4) % SIZE_FFT];
  endfunction

  function automatic logic [31:0] exp_im(input int n);
    return 32'd0 - tab[exp_k(n)];
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_val"},  32'(out_val), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_re"},   twiddle_real, 32'd0);
    chk({nm, "_im"},   twiddle_imag, 32'd0);
    chk({nm, "_stg"},  32'(stage), 32'd0);
    chk({nm, "_bfly"}, 32'(bfly_idx), 32'd0);
  endtask

  // Runs one sequence: pulses start, accepts with rdy_pct % probability, scoreboards every transfer.
  // stall_at >= 0 forces 3 stall cycles on that transfer; abort_at >= 0 pulls reset at that transfer.
  task automatic run_seq(input string nm, input int rdy_pct, input bit start_noise,
                         input int stall_at, input int abort_at);
    int ntx;
    int cyc;
    int done_cnt;
    int run_cyc;
    int last_tx_cyc;
    int done_cyc;
    int stall_cnt;
    bit fin;
    bit aborted;
    bit rdy;
    bit prev_stall;
    bit post_stall_seen;
    logic [31:0] h_re;
    logic [31:0] h_im;
    logic [31:0] h_st;
    logic [31:0] h_bf;
    ntx = 0; cyc = 0; done_cnt = 0; run_cyc = 0; last_tx_cyc = -10; done_cyc = -1;
    stall_cnt = 0; fin = 1'b0; aborted = 1'b0; prev_stall = 1'b0; post_stall_seen = 1'b0;
    h_re = '0; h_im = '0; h_st = '0; h_bf = '0;

    @(negedge clk);
    start   = 1'b1;
    out_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_lat1_val"},  32'(out_val), 32'd1);
    chk({nm, "_lat1_busy"}, 32'(busy), 32'd1);

    while (!fin && cyc < 3000) begin
      if (abort_at >= 0 && ntx == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk_all_zero({nm, "_async"});
        chk({nm, "_no_done_aborted"}, 32'(done_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk({nm, "_post_rel_done"}, 32'(done), 32'd0);
        chk({nm, "_post_rel_val"},  32'(out_val), 32'd0);
        aborted = 1'b1;
        fin     = 1'b1;
      end else begin
        if (prev_stall) begin
          chk({nm, "_hold_re"},   twiddle_real, h_re);
          chk({nm, "_hold_im"},   twiddle_imag, h_im);
          chk({nm, "_hold_stg"},  32'(stage), h_st);
          chk({nm, "_hold_bfly"}, 32'(bfly_idx), h_bf);
        end
        prev_stall = 1'b0;

        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk({nm, "_done_busy"}, 32'(busy), 32'd0);
          chk({nm, "_done_val"},  32'(out_val), 32'd0);
          start = start_noise;   // must be ignored in DONE
        end else if (done_cyc >= 0) begin
          chk({nm, "_idle_done"}, 32'(done), 32'd0);
          chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
          chk({nm, "_idle_val"},  32'(out_val), 32'd0);
          start = 1'b0;
          fin   = 1'b1;
        end

        if (out_val) begin
          run_cyc++;
          if (stall_at >= 0 && ntx == stall_at + 1 && stall_cnt == 3 && !post_stall_seen) begin
            post_stall_seen = 1'b1;
            chk({nm, "_rel_bfly"}, 32'(bfly_idx), 32'd5);
            chk({nm, "_rel_re"},   twiddle_real, 32'd36409);
            chk({nm, "_rel_im"},   twiddle_imag, -32'sd54491);
          end
          if (stall_at == ntx && stall_cnt < 3) begin
            rdy = 1'b0;
            stall_cnt++;
            chk({nm, "_frz_re"},   twiddle_real, 32'd46340);
            chk({nm, "_frz_im"},   twiddle_imag, -32'sd46340);
            chk({nm, "_frz_stg"},  32'(stage), 32'd4);
            chk({nm, "_frz_bfly"}, 32'(bfly_idx), 32'd4);
          end else begin
            rdy = ($urandom_range(99) < rdy_pct);
          end
          out_rdy = rdy;
          if (rdy) begin
            if (ntx < NTX) begin
              chk({nm, "_sb_stg"},  32'(stage), 32'(ntx / 16));
              chk({nm, "_sb_bfly"}, 32'(bfly_idx), 32'(ntx % 16));
              chk({nm, "_sb_re"},   twiddle_real, exp_re(ntx));
              chk({nm, "_sb_im"},   twiddle_imag, exp_im(ntx));
              cap_re[ntx] = twiddle_real;
              cap_im[ntx] = twiddle_imag;
            end
            ntx++;
            last_tx_cyc = cyc;
          end else begin
            prev_stall = 1'b1;
            h_re = twiddle_real;
            h_im = twiddle_imag;
            h_st = 32'(stage);
            h_bf = 32'(bfly_idx);
          end
          if (start_noise) start = 1'($urandom_range(1));
        end
        cyc++;
        if (!fin) @(negedge clk);
      end
    end
    out_rdy = 1'b0;
    start   = 1'b0;

    if (!aborted) begin
      chk({nm, "_ntx"},       32'(ntx), 32'(NTX));
      chk({nm, "_done_cnt"},  32'(done_cnt), 32'd1);
      chk({nm, "_done_after"}, 32'(done_cyc), 32'(last_tx_cyc + 1));
      if (rdy_pct == 100 && stall_at < 0) begin
        chk({nm, "_b2b_cycles"}, 32'(run_cyc), 32'(NTX));
      end
    end
  endtask

  initial begin
    int base [0:8];
    n_chk = 0;
    n_err = 0;
    clk     = 1'b0;
    reset   = 1'b0;
    start   = 1'b1;
    out_rdy = 1'b0;

    base = '{0, 12785, 25079, 36409, 46340, 54491, 60547, 64276, 65536};
    for (int i = 0; i < 8; i++) begin
      tab[i]      = 32'(base[i]);
      tab[16 - i] = 32'(base[i]);
      tab[16 + i] = 32'(-base[i]);
      tab[32 - i - 0 - (i == 0 ? 16 : 0)] = 32'(-base[i]);
    end
    tab[8]  = 32'd65536;
    tab[24] = -32'sd65536;

    // Reset held with start high: everything zero.
    #3;
    chk_all_zero("rst");
    repeat (2) @(negedge clk);
    chk_all_zero("rst_clk");

    // Release with start low: stays idle.
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_val",  32'(out_val), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    run_seq("full", 100, 1'b0, -1, -1);
    for (int b = 0; b < 16; b++) begin
      chk("s0_re", cap_re[b], 32'd65536);
      chk("s0_im", cap_im[b], 32'd0);
    end
    chk("s1b1_re",  cap_re[17], 32'd0);
    chk("s1b1_im",  cap_im[17], 32'hFFFF0000);
    chk("s4b1_re",  cap_re[65], 32'd64276);
    chk("s4b1_im",  cap_im[65], -32'sd12785);
    chk("s4b4_re",  cap_re[68], 32'd46340);
    chk("s4b4_im",  cap_im[68], -32'sd46340);
    chk("s4b15_re", cap_re[79], -32'sd64276);
    chk("s4b15_im", cap_im[79], -32'sd12785);

    run_seq("bp", 100, 1'b0, 68, -1);
    run_seq("rand", 50, 1'b0, -1, -1);
    run_seq("stnoise", 100, 1'b1, -1, -1);
    repeat (3) @(negedge clk);
    chk("noise_idle_busy", 32'(busy), 32'd0);
    run_seq("restart", 100, 1'b0, -1, -1);
    run_seq("abort", 100, 1'b0, -1, 37);
    run_seq("after_abort", 70, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
